// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: passive receiver for an HD44780-style character LCD bus.
// Synchronizes the pin interface, turns each qualified EN write cycle into a
// command or data byte, and maintains a 2x16 register mirror of the display.
module lcd_bus_decoder #(
    parameter int EN_MIN_HIGH = 4
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iLCD_DATA,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic       iLCD_EN,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_CHAR,
    output logic [6:0] oDDADDR,
    output logic       oDISP_ON,
    output logic       oTWO_LINE,
    output logic       oWR_STB,
    output logic       oCMD_STB,
    output logic [7:0] oCMD,
    output logic       oERR
);

    localparam logic [7:0] EN_MIN = 8'(EN_MIN_HIGH);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_e;

    // Pin synchronizer stages, packed as {en, rw, rs, data}
    logic [10:0] pins_meta_q;
    logic [10:0] pins_sync_q;
    logic [7:0]  en_cnt_q;
    logic [9:0]  cap_q;          // {rw, rs, data} from the last EN-high cycle

    state_e      state_q;
    logic        exec_rs_q;
    logic [7:0]  exec_byte_q;
    logic        pend_valid_q;
    logic        pend_rs_q;
    logic [7:0]  pend_byte_q;
    logic [4:0]  clr_idx_q;
    logic [6:0]  ddaddr_q;
    logic        id_q;
    logic        disp_on_q;
    logic        two_line_q;
    logic        cgram_q;
    logic [7:0]  cmd_q;
    logic        wr_stb_q;
    logic        cmd_stb_q;
    logic        err_q;
    logic [7:0]  mirror_q [32];

    logic en_sync;
    logic strobe;
    logic cmd_strobe;
    logic rw_strobe;

    // DDRAM addresses that exist on a two-line display
    function automatic logic addr_legal(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Address counter step with line wrap; an illegal address restarts at 0
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (!addr_legal(a))   r = 7'h00;
        else if (inc)         r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else                  r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        return r;
    endfunction

    assign en_sync    = pins_sync_q[10];
    assign strobe     = !en_sync && (en_cnt_q >= EN_MIN);
    assign cmd_strobe = strobe && !cap_q[9];
    assign rw_strobe  = strobe && cap_q[9];

    // Two-flop pin synchronizer, EN-high run counter and write-cycle capture
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pins_meta_q <= '0;
            pins_sync_q <= '0;
            en_cnt_q    <= '0;
            cap_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments let both flops sample in the same edge, forming a real 2-stage chain.
            pins_meta_q <= {iLCD_EN, iLCD_RW, iLCD_RS, iLCD_DATA};
            pins_sync_q <= pins_meta_q;
            if (en_sync) begin
                en_cnt_q <= (en_cnt_q == 8'hFF) ? en_cnt_q : en_cnt_q + 8'd1;
                cap_q    <= pins_sync_q[9:0];
            end else begin
                en_cnt_q <= '0;
            end
        end
    end

    // Bus FSM: accept strobes, execute commands/data, run the 32-cycle clear
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= ST_IDLE;
            exec_rs_q    <= 1'b0;
            exec_byte_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_rs_q    <= 1'b0;
            pend_byte_q  <= '0;
            clr_idx_q    <= '0;
            ddaddr_q     <= '0;
            id_q         <= 1'b1;
            disp_on_q    <= 1'b0;
            two_line_q   <= 1'b1;
            cgram_q      <= 1'b0;
            cmd_q        <= '0;
            wr_stb_q     <= 1'b0;
            cmd_stb_q    <= 1'b0;
            err_q        <= 1'b0;
            // NOTE: the mirror is a small flop array, so it is reset here; a RAM-mapped array could not be.
            for (int i = 0; i < 32; i++) mirror_q[i] <= 8'h20;
        end else begin
            wr_stb_q  <= 1'b0;
            cmd_stb_q <= 1'b0;
            err_q     <= rw_strobe;

            // Busy: park one strobe, drop anything beyond that
            if ((state_q != ST_IDLE) && cmd_strobe) begin
                if (pend_valid_q) begin
                    err_q <= 1'b1;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_rs_q    <= cap_q[8];
                    pend_byte_q  <= cap_q[7:0];
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (pend_valid_q) begin
                        exec_rs_q   <= pend_rs_q;
                        exec_byte_q <= pend_byte_q;
                        state_q     <= ST_EXEC;
                        if (cmd_strobe) begin
                            pend_rs_q   <= cap_q[8];
                            pend_byte_q <= cap_q[7:0];
                        end else begin
                            pend_valid_q <= 1'b0;
                        end
                    end else if (cmd_strobe) begin
                        exec_rs_q   <= cap_q[8];
                        exec_byte_q <= cap_q[7:0];
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    if (exec_rs_q) begin
                        wr_stb_q <= 1'b1;
                        if (!cgram_q) begin
                            if (ddaddr_q[5:4] == 2'b00)
                                mirror_q[{ddaddr_q[6], ddaddr_q[3:0]}] <= exec_byte_q;
                            ddaddr_q <= addr_step(ddaddr_q, id_q);
                        end
                    end else begin
                        cmd_stb_q <= 1'b1;
                        cmd_q     <= exec_byte_q;
                        casez (exec_byte_q)
                            8'b1???????: begin
                                ddaddr_q <= exec_byte_q[6:0];
                                cgram_q  <= 1'b0;
                                if (!addr_legal(exec_byte_q[6:0])) err_q <= 1'b1;
                            end
                            8'b01??????: begin
                                cgram_q <= 1'b1;
                                err_q   <= 1'b1;
                            end
                            8'b001?????: two_line_q <= exec_byte_q[3];
                            8'b0001????: begin
                                if (exec_byte_q[3]) err_q <= 1'b1;
                                else                ddaddr_q <= addr_step(ddaddr_q, exec_byte_q[2]);
                            end
                            8'b00001???: disp_on_q <= exec_byte_q[2];
                            8'b000001??: begin
                                id_q <= exec_byte_q[1];
                                if (exec_byte_q[0]) err_q <= 1'b1;
                            end
                            8'b0000001?: ddaddr_q <= 7'h00;
                            8'b00000001: begin
                                clr_idx_q <= '0;
                                state_q   <= ST_CLEAR;
                            end
                            default:     err_q <= 1'b1;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    mirror_q[clr_idx_q] <= 8'h20;
                    clr_idx_q           <= clr_idx_q + 5'd1;
                    if (clr_idx_q == 5'd31) begin
                        ddaddr_q <= 7'h00;
                        id_q     <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oRD_CHAR  = mirror_q[iRD_ADDR];
    assign oDDADDR   = ddaddr_q;
    assign oDISP_ON  = disp_on_q;
    assign oTWO_LINE = two_line_q;
    assign oWR_STB   = wr_stb_q;
    assign oCMD_STB  = cmd_stb_q;
    assign oCMD      = cmd_q;
    assign oERR      = err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: directed bus sequences plus random traffic,
// compared against a byte-level display model.
module tb_lcd_bus_decoder;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [7:0] iLCD_DATA;
    logic       iLCD_RS;
    logic       iLCD_RW;
    logic       iLCD_EN;
    logic [4:0] iRD_ADDR;
    logic [7:0] oRD_CHAR;
    logic [6:0] oDDADDR;
    logic       oDISP_ON;
    logic       oTWO_LINE;
    logic       oWR_STB;
    logic       oCMD_STB;
    logic [7:0] oCMD;
    logic       oERR;

    lcd_bus_decoder #(.EN_MIN_HIGH(4)) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iLCD_DATA (iLCD_DATA),
        .iLCD_RS   (iLCD_RS),
        .iLCD_RW   (iLCD_RW),
        .iLCD_EN   (iLCD_EN),
        .iRD_ADDR  (iRD_ADDR),
        .oRD_CHAR  (oRD_CHAR),
        .oDDADDR   (oDDADDR),
        .oDISP_ON  (oDISP_ON),
        .oTWO_LINE (oTWO_LINE),
        .oWR_STB   (oWR_STB),
        .oCMD_STB  (oCMD_STB),
        .oCMD      (oCMD),
        .oERR      (oERR)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    // Pulse counters for the three one-cycle outputs
    int wr_seen  = 0;
    int cmd_seen = 0;
    int err_seen = 0;
    always @(negedge iCLK) begin
        if (oWR_STB)  wr_seen++;
        if (oCMD_STB) cmd_seen++;
        if (oERR)     err_seen++;
    end

    // Reference display model
    logic [7:0] m_mirror [32];
    int         m_addr;
    bit         m_id, m_disp, m_two, m_cgram;
    logic [7:0] m_cmd;
    int         m_wr = 0, m_cmdn = 0, m_err = 0;

    function automatic bit legal(int a);
        return (a >= 0 && a <= 39) || (a >= 64 && a <= 103);
    endfunction

    function automatic int next_addr(int a, bit inc);
        if (!legal(a)) return 0;
        if (inc) begin
            if (a == 39)  return 64;
            if (a == 103) return 0;
            return a + 1;
        end
        if (a == 0)  return 103;
        if (a == 64) return 39;
        return a - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mirror[i] = 8'h20;
        m_addr  = 0;
        m_id    = 1'b1;
        m_disp  = 1'b0;
        m_two   = 1'b1;
        m_cgram = 1'b0;
        m_cmd   = 8'h00;
    endtask

    task automatic model_apply(bit rs, logic [7:0] b);
        int line, col;
        if (rs) begin
            m_wr++;
            if (!m_cgram) begin
                line = (m_addr >= 64) ? 1 : 0;
                col  = m_addr - 64 * line;
                if (col >= 0 && col < 16) m_mirror[line * 16 + col] = b;
                m_addr = next_addr(m_addr, m_id);
            end
        end else begin
            m_cmdn++;
            m_cmd = b;
            if (b >= 8'h80) begin
                m_addr  = int'(b) - 128;
                m_cgram = 1'b0;
                if (!legal(m_addr)) m_err++;
            end else if (b >= 8'h40) begin
                m_cgram = 1'b1;
                m_err++;
            end else if (b >= 8'h20) begin
                m_two = b[3];
            end else if (b >= 8'h10) begin
                if (b[3]) m_err++;
                else      m_addr = next_addr(m_addr, b[2]);
            end else if (b >= 8'h08) begin
                m_disp = b[2];
            end else if (b >= 8'h04) begin
                m_id = b[1];
                if (b[0]) m_err++;
            end else if (b >= 8'h02) begin
                m_addr = 0;
            end else if (b == 8'h01) begin
                for (int i = 0; i < 32; i++) m_mirror[i] = 8'h20;
                m_addr = 0;
                m_id   = 1'b1;
            end else begin
                m_err++;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(string tag);
        #1;
        check({tag, " ddaddr"},   32'(oDDADDR),   m_addr);
        check({tag, " disp_on"},  32'(oDISP_ON),  32'(m_disp));
        check({tag, " two_line"}, 32'(oTWO_LINE), 32'(m_two));
        check({tag, " cmd"},      32'(oCMD),      32'(m_cmd));
        check({tag, " wr_cnt"},   wr_seen,        m_wr);
        check({tag, " cmd_cnt"},  cmd_seen,       m_cmdn);
        check({tag, " err_cnt"},  err_seen,       m_err);
    endtask

    task automatic check_mirror(string tag);
        for (int i = 0; i < 32; i++) begin
            iRD_ADDR = 5'(i);
            #1;
            check($sformatf("%s mirror[%0d]", tag, i), 32'(oRD_CHAR), 32'(m_mirror[i]));
        end
    endtask

    // One bus write cycle with EN held high for 'high' clocks
    task automatic drive_cycle(bit rs, bit rw, logic [7:0] b, int high);
        @(negedge iCLK);
        iLCD_DATA = b;
        iLCD_RS   = rs;
        iLCD_RW   = rw;
        iLCD_EN   = 1'b1;
        repeat (high) @(negedge iCLK);
        iLCD_EN   = 1'b0;
    endtask

    // Full-length write, mirrored in the model, then idle long enough to finish
    task automatic send(bit rs, logic [7:0] b);
        drive_cycle(rs, 1'b0, b, 8);
        model_apply(rs, b);
        repeat ((!rs && b == 8'h01) ? 45 : 8) @(negedge iCLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] text [5];
        bit         rs;
        logic [7:0] b;
        text = '{8'h32, 8'h35, 8'h30, 8'h7C, 8'h7C};

        iRST_N    = 1'b0;
        iLCD_DATA = 8'h00;
        iLCD_RS   = 1'b0;
        iLCD_RW   = 1'b0;
        iLCD_EN   = 1'b0;
        iRD_ADDR  = 5'd0;
        model_reset();
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        check_regs("reset");
        check_mirror("reset");

        // Standard init sequence
        send(1'b0, 8'h38);
        send(1'b0, 8'h0C);
        send(1'b0, 8'h01);
        send(1'b0, 8'h06);
        send(1'b0, 8'h80);
        check_regs("init");
        check_mirror("init");

        // Text on line 0
        for (int i = 0; i < 5; i++) send(1'b1, text[i]);
        check_regs("text");
        check_mirror("text");

        // Line 1 start, line 1 last column, then a write past the window
        send(1'b0, 8'hC0);
        send(1'b1, 8'h31);
        send(1'b0, 8'hCF);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        check_regs("line1");
        check_mirror("line1");

        // Decrement mode wraps 0x00 -> 0x67, cursor right wraps 0x67 -> 0x00
        send(1'b0, 8'h04);
        send(1'b0, 8'h80);
        send(1'b1, 8'h58);
        check_regs("dec");
        send(1'b0, 8'h14);
        check_regs("cursor");
        check_mirror("dec");

        // Too-short EN pulse is ignored
        drive_cycle(1'b1, 1'b0, 8'h77, 2);
        repeat (8) @(negedge iCLK);
        check_regs("short_en");

        // Read cycle only raises oERR
        drive_cycle(1'b0, 1'b1, 8'h80, 8);
        m_err++;
        repeat (8) @(negedge iCLK);
        check_regs("rw");

        // CGRAM mode swallows data
        send(1'b0, 8'h40);
        send(1'b1, 8'h55);
        check_regs("cgram");
        check_mirror("cgram");
        send(1'b0, 8'h80);

        // Strobes during clear: first is parked, second is dropped
        drive_cycle(1'b0, 1'b0, 8'h01, 8);
        model_apply(1'b0, 8'h01);
        @(negedge iCLK);
        drive_cycle(1'b1, 1'b0, 8'h41, 4);
        model_apply(1'b1, 8'h41);
        drive_cycle(1'b1, 1'b0, 8'h42, 4);
        m_err++;
        repeat (45) @(negedge iCLK);
        check_regs("pending");
        check_mirror("pending");

        // Reset in the middle of a clear with a parked data byte
        drive_cycle(1'b0, 1'b0, 8'h01, 8);
        m_cmdn++;
        repeat (2) @(negedge iCLK);
        drive_cycle(1'b1, 1'b0, 8'h5A, 4);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b0;
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (40) @(negedge iCLK);
        check_regs("mid_clear_reset");
        check_mirror("mid_clear_reset");

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            rs = 1'($urandom_range(0, 1));
            if (rs) b = 8'($urandom_range(8'h21, 8'h7E));
            else    b = 8'($urandom);
            send(rs, b);
            check_regs($sformatf("rand%0d", n));
            if (n % 10 == 9) check_mirror($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
